pc_sequencer: RTL and testbench

//  Next-PC controller for the 5-stage pipeline; sole driver of the PC register's PCSrc and datahazard (stall) inputs.

---
 rtl/pc_sequencer_if.sv | 29 ++
 rtl/pc_sequencer.sv | 126 ++++++++++++
 tb/tb_pc_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Signal bundle between the next-PC sequencer and the pipeline: redirect requests in,
// PC source select, stall, flushes and trap acknowledges out.
interface pc_sequencer_if;
    logic       irq;
    logic       kernel;
    logic       id_jump;
    logic       id_jr;
    logic       id_undef;
    logic       id_load_use;
    logic       ex_branch;
    logic       ex_taken;
    logic [2:0] PCSrc;
    logic       datahazard;
    logic       flush_ifid;
    logic       flush_idex;
    logic       irq_ack;
    logic       xcpt_ack;
    logic       busy;

    modport master (
        output irq, kernel, id_jump, id_jr, id_undef, id_load_use, ex_branch, ex_taken,
        input  PCSrc, datahazard, flush_ifid, flush_idex, irq_ack, xcpt_ack, busy
    );

    modport slave (
        input  irq, kernel, id_jump, id_jr, id_undef, id_load_use, ex_branch, ex_taken,
        output PCSrc, datahazard, flush_ifid, flush_idex, irq_ack, xcpt_ack, busy
    );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller: arbitrates branch/jump/trap/stall redirects each cycle and drives
// PCSrc, the PC hold, pipeline flushes and trap acknowledges.
module pc_sequencer #(
    parameter int STALL_CYCLES = 1,
    parameter int IRQ_SYNC     = 2,
    parameter int HOLDOFF      = 2
) (
    input  logic          clk,
    input  logic          reset,
    pc_sequencer_if.slave bus
);
    localparam logic [2:0] SRC_PC4  = 3'b000;
    localparam logic [2:0] SRC_BR   = 3'b001;
    localparam logic [2:0] SRC_J    = 3'b010;
    localparam logic [2:0] SRC_JR   = 3'b011;
    localparam logic [2:0] SRC_IRQ  = 3'b100;
    localparam logic [2:0] SRC_XCPT = 3'b101;
    localparam logic [2:0] STALL_LD = 3'(STALL_CYCLES - 1);
    localparam logic [3:0] HOLD_LD  = 4'(HOLDOFF);

    typedef enum logic [1:0] {RUN, STALL, HOLD} state_t;

    state_t              state, state_nxt;
    logic [2:0]          cnt, cnt_nxt;
    logic [3:0]          holdoff, holdoff_nxt;
    logic [IRQ_SYNC-1:0] irq_sync;
    logic                irq_s;
    logic                br_taken;
    logic [2:0]          pcsrc;
    logic                hold_pc;
    logic                fl_ifid;
    logic                fl_idex;
    logic                ack_irq;
    logic                ack_xcpt;

    assign irq_s    = irq_sync[IRQ_SYNC-1];
    assign br_taken = bus.ex_branch & bus.ex_taken;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            cnt      <= 3'd0;
            holdoff  <= 4'd0;
            irq_sync <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            holdoff  <= holdoff_nxt;
            irq_sync <= IRQ_SYNC'({irq_sync, bus.irq});
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        holdoff_nxt = (holdoff != 4'd0) ? holdoff - 4'd1 : 4'd0;
        pcsrc       = SRC_PC4;
        hold_pc     = 1'b0;
        fl_ifid     = 1'b0;
        fl_idex     = 1'b0;
        ack_irq     = 1'b0;
        ack_xcpt    = 1'b0;

        if (state == STALL) begin
            // A taken branch makes the stalled ID instruction dead, so the stall is abandoned.
            if (br_taken) begin
                pcsrc     = SRC_BR;
                fl_ifid   = 1'b1;
                fl_idex   = 1'b1;
                state_nxt = RUN;
                cnt_nxt   = 3'd0;
            end else begin
                hold_pc = 1'b1;
                fl_idex = 1'b1;
                cnt_nxt = cnt - 3'd1;
                if (cnt == 3'd1)
                    state_nxt = RUN;
            end
        end else begin
            if (state == HOLD && holdoff <= 4'd1)
                state_nxt = RUN;

            if (br_taken) begin
                pcsrc   = SRC_BR;
                fl_ifid = 1'b1;
                fl_idex = 1'b1;
            end else if (bus.id_undef) begin
                pcsrc       = SRC_XCPT;
                ack_xcpt    = 1'b1;
                fl_ifid     = 1'b1;
                fl_idex     = 1'b1;
                holdoff_nxt = HOLD_LD;
                state_nxt   = (HOLDOFF > 0) ? HOLD : RUN;
            end else if (state == RUN && irq_s && !bus.kernel && holdoff == 4'd0) begin
                pcsrc       = SRC_IRQ;
                ack_irq     = 1'b1;
                fl_ifid     = 1'b1;
                fl_idex     = 1'b1;
                holdoff_nxt = HOLD_LD;
                state_nxt   = (HOLDOFF > 0) ? HOLD : RUN;
            end else if (bus.id_load_use) begin
                hold_pc = 1'b1;
                fl_idex = 1'b1;
                if (STALL_CYCLES > 1) begin
                    state_nxt = STALL;
                    cnt_nxt   = STALL_LD;
                end
            end else if (bus.id_jr) begin
                pcsrc   = SRC_JR;
                fl_ifid = 1'b1;
            end else if (bus.id_jump) begin
                pcsrc   = SRC_J;
                fl_ifid = 1'b1;
            end
        end
    end

    // While reset is held every output is forced quiet, whatever the request inputs do.
    assign bus.PCSrc      = reset ? pcsrc    : SRC_PC4;
    assign bus.datahazard = reset & hold_pc;
    assign bus.flush_ifid = reset & fl_ifid;
    assign bus.flush_idex = reset & fl_idex;
    assign bus.irq_ack    = reset & ack_irq;
    assign bus.xcpt_ack   = reset & ack_xcpt;
    assign bus.busy       = reset & (state != RUN);
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic against a
// rule-level reference model of the next-PC arbitration.
module tb_pc_sequencer;
    localparam int STALL_CYCLES = 2;
    localparam int IRQ_SYNC     = 2;
    localparam int HOLDOFF      = 2;

    logic clk;
    logic reset;
    pc_sequencer_if seq_if();

    pc_sequencer #(
        .STALL_CYCLES(STALL_CYCLES),
        .IRQ_SYNC    (IRQ_SYNC),
        .HOLDOFF     (HOLDOFF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (seq_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model state: cycles of stall left, trap holdoff left, hold-mode flag, irq history.
    int         stall_left;
    int         hold_left;
    bit         hold_mode;
    bit         irq_q[$];
    logic [8:0] exp_v;
    logic [8:0] last_obs;

    task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%b exp=%b (PCSrc,dh,fifid,fidex,iack,xack,busy) t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        stall_left = 0;
        hold_left  = 0;
        hold_mode  = 0;
        irq_q.delete();
        for (int i = 0; i < IRQ_SYNC; i++) irq_q.push_back(1'b0);
    endtask

    // Evaluates the arbitration rules for the current cycle, then advances to the next edge.
    task automatic model_step();
        bit bt, irq_s, dh, fi, fx, ia, xa, bz, trap, stall_go;
        logic [2:0] src;
        int stall_n;
        bt = seq_if.ex_branch & seq_if.ex_taken;
        irq_s = irq_q[0];
        src = 3'd0; dh = 0; fi = 0; fx = 0; ia = 0; xa = 0; trap = 0; stall_go = 0;
        stall_n = stall_left;
        if (stall_left > 0) begin
            bz = 1;
            if (bt) begin
                src = 3'd1; fi = 1; fx = 1; stall_n = 0;
            end else begin
                dh = 1; fx = 1; stall_n = stall_left - 1;
            end
        end else begin
            bz = hold_mode;
            if (bt) begin
                src = 3'd1; fi = 1; fx = 1;
            end else if (seq_if.id_undef) begin
                src = 3'd5; xa = 1; fi = 1; fx = 1; trap = 1;
            end else if (irq_s && !seq_if.kernel && hold_left == 0) begin
                src = 3'd4; ia = 1; fi = 1; fx = 1; trap = 1;
            end else if (seq_if.id_load_use) begin
                dh = 1; fx = 1;
                if (STALL_CYCLES > 1) begin
                    stall_n = STALL_CYCLES - 1;
                    stall_go = 1;
                end
            end else if (seq_if.id_jr) begin
                src = 3'd3; fi = 1;
            end else if (seq_if.id_jump) begin
                src = 3'd2; fi = 1;
            end
        end
        exp_v = {src, dh, fi, fx, ia, xa, bz};

        if (trap)                hold_mode = (HOLDOFF > 0);
        else if (stall_go)       hold_mode = 0;
        else if (hold_left <= 1) hold_mode = 0;
        hold_left  = trap ? HOLDOFF : ((hold_left > 0) ? hold_left - 1 : 0);
        stall_left = stall_n;
        irq_q.push_back(seq_if.irq);
        void'(irq_q.pop_front());
    endtask

    function automatic logic [8:0] outs();
        return {seq_if.PCSrc, seq_if.datahazard, seq_if.flush_ifid, seq_if.flush_idex,
                seq_if.irq_ack, seq_if.xcpt_ack, seq_if.busy};
    endfunction

    // Called at posedge+1 with inputs set; compares at the falling edge.
    task automatic cycle(input string tag);
        @(negedge clk);
        model_step();
        last_obs = outs();
        chk(tag, last_obs, exp_v);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        seq_if.id_jump = 0; seq_if.id_jr = 0; seq_if.id_undef = 0; seq_if.id_load_use = 0;
        seq_if.ex_branch = 0; seq_if.ex_taken = 0;
    endtask

    task automatic drain(input int n);
        clear_inputs();
        seq_if.irq = 0;
        seq_if.kernel = 0;
        for (int i = 0; i < n; i++) cycle("drain");
    endtask

    // Asserts reset between edges, checks outputs go quiet at once, releases after the next edge.
    task automatic async_reset(input string tag);
        #1;
        reset = 0;
        #1;
        chk(tag, outs(), 9'b0);
        model_reset();
        @(posedge clk);
        #2;
        reset = 1;
    endtask

    initial begin
        bit any_ack;
        reset = 0;
        seq_if.irq = 0;
        seq_if.kernel = 0;
        clear_inputs();
        seq_if.id_jump = 1; seq_if.ex_branch = 1; seq_if.ex_taken = 1; seq_if.id_undef = 1;
        model_reset();
        #3;
        chk("reset_outs", outs(), 9'b0);
        @(posedge clk);
        #1;
        reset = 1;
        clear_inputs();
        cycle("idle0");
        chk("idle_pc4", last_obs, 9'b0);

        // Load-use stall spans two cycles.
        seq_if.id_load_use = 1;
        cycle("t1_c0");
        chk("t1_stall0", last_obs, 9'b000101000);
        seq_if.id_load_use = 0;
        cycle("t1_c1");
        chk("t1_stall1", last_obs, 9'b000101001);
        cycle("t1_c2");
        chk("t1_resume", last_obs, 9'b0);

        // Taken branch beats jump; not-taken falls through to jump.
        seq_if.ex_branch = 1; seq_if.ex_taken = 1; seq_if.id_jump = 1;
        cycle("t2_c0");
        chk("t2_branch", last_obs, 9'b001011000);
        seq_if.ex_taken = 0;
        cycle("t2_c1");
        chk("t2_jump", last_obs, 9'b010010000);
        drain(2);

        // Interrupt through the synchroniser, then retaken after the holdoff.
        seq_if.irq = 1;
        cycle("t3_c0");
        chk("t3_lat0", last_obs, 9'b0);
        cycle("t3_c1");
        chk("t3_lat1", last_obs, 9'b0);
        cycle("t3_c2");
        chk("t3_ack", last_obs, 9'b100011100);
        cycle("t3_c3");
        chk("t3_hold0", last_obs, 9'b000000001);
        cycle("t3_c4");
        chk("t3_hold1", last_obs, 9'b000000001);
        cycle("t3_c5");
        chk("t3_reack", last_obs, 9'b100011100);
        drain(5);

        // Kernel mode masks the interrupt until it drops.
        seq_if.irq = 1;
        seq_if.kernel = 1;
        any_ack = 0;
        for (int i = 0; i < 20; i++) begin
            cycle("t4_masked");
            any_ack |= last_obs[2];
        end
        chk("t4_no_ack", {8'b0, any_ack}, 9'b0);
        seq_if.kernel = 0;
        cycle("t4_unmask");
        chk("t4_ack", {8'b0, last_obs[2]}, 9'b1);
        drain(5);

        // Exception outranks interrupt and load-use in the same cycle.
        seq_if.irq = 1;
        seq_if.kernel = 1;
        for (int i = 0; i < 3; i++) cycle("t5_pre");
        seq_if.kernel = 0; seq_if.id_undef = 1; seq_if.id_load_use = 1;
        cycle("t5_c0");
        chk("t5_xcpt", last_obs, 9'b101011010);
        drain(5);

        // Asynchronous reset in the middle of a stall.
        seq_if.id_load_use = 1;
        cycle("t6_c0");
        seq_if.id_load_use = 0;
        async_reset("t6_reset");
        cycle("t6_c1");
        chk("t6_resume", last_obs, 9'b0);

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(19) == 0) seq_if.irq = ~seq_if.irq;
            if ($urandom_range(14) == 0) seq_if.kernel = ~seq_if.kernel;
            seq_if.ex_branch   = ($urandom_range(5) == 0);
            seq_if.ex_taken    = $urandom_range(1) == 1;
            seq_if.id_undef    = ($urandom_range(19) == 0);
            seq_if.id_load_use = ($urandom_range(4) == 0);
            seq_if.id_jr       = ($urandom_range(7) == 0);
            seq_if.id_jump     = ($urandom_range(7) == 0);
            if ($urandom_range(249) == 0)
                async_reset("rnd_reset");
            cycle("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
